// File: rtl/bus_arb_pkg.sv
// Shared definitions for the two-master bus arbiter: state encoding,
// counter width and the read data returned on a timeout abort.
package bus_arb_pkg;

    localparam int          CNT_W      = 8;
    localparam int          ADDR_W     = 32;
    localparam int          DATA_W     = 32;
    localparam logic [31:0] ERR_RDDATA = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// One simple stall-handshake bus port: request fields flow master->slave,
// read data and stall flow back.
interface bus_arbiter_if;
    import bus_arb_pkg::*;

    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] wrdata;
    logic [DATA_W-1:0] rddata;
    logic              stall;

    modport master (output address, byteenable, read, write, wrdata,
                    input  rddata, stall);
    modport slave  (input  address, byteenable, read, write, wrdata,
                    output rddata, stall);
endinterface

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// master that was not served last.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);
    assign valid  = |req;
    assign winner = (req == 2'b11) ? ~last : req[1];
endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates instruction-fetch (m0) and data (m1) masters onto one shared
// port, with zero-cycle grant from IDLE and a stall timeout abort.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    bus_arbiter_if.slave   m0,
    bus_arbiter_if.slave   m1,
    bus_arbiter_if.master  s,
    output logic           bus_err
);
    localparam logic [CNT_W:0] TIMEOUT_C = (CNT_W+1)'(TIMEOUT);
    localparam logic [CNT_W:0] ONE_C     = {{CNT_W{1'b0}}, 1'b1};

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q,  last_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic [1:0]        req;
    logic              rr_valid, rr_winner;
    logic              sel, pass, err;
    logic [CNT_W:0]    cnt_nxt;

    assign req     = {m1.read | m1.write, m0.read | m0.write};
    assign cnt_nxt = {1'b0, cnt_q} + ONE_C;

    arb_rr2 u_rr (
        .req    (req),
        .last   (last_q),
        .valid  (rr_valid),
        .winner (rr_winner)
    );

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        sel     = 1'b0;
        pass    = 1'b0;
        err     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rr_valid) begin
                    sel  = rr_winner;
                    pass = 1'b1;
                    if (s.stall) begin
                        state_d = ST_BUSY;
                        owner_d = rr_winner;
                        cnt_d   = ONE_C[CNT_W-1:0];
                    end else begin
                        last_d  = rr_winner;
                    end
                end
            end
            ST_BUSY: begin
                sel = owner_q;
                if (!req[owner_q]) begin
                    state_d = ST_IDLE;
                end else begin
                    pass = 1'b1;
                    if (!s.stall) begin
                        state_d = ST_IDLE;
                        last_d  = owner_q;
                    end else begin
                        cnt_d = cnt_nxt[CNT_W] ? cnt_q : cnt_nxt[CNT_W-1:0];
                        if (cnt_nxt == TIMEOUT_C) state_d = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                sel     = owner_q;
                err     = 1'b1;
                state_d = ST_IDLE;
                last_d  = owner_q;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d != ST_BUSY) cnt_d = '0;
    end

    // Requesters stall by default; only the bus holder sees the shared response.
    always_comb begin
        s.address    = '0;
        s.byteenable = '0;
        s.read       = 1'b0;
        s.write      = 1'b0;
        s.wrdata     = '0;
        m0.rddata    = '0;
        m1.rddata    = '0;
        m0.stall     = req[0];
        m1.stall     = req[1];
        bus_err      = 1'b0;
        if (!rst) begin
            if (pass) begin
                if (sel) begin
                    s.address = m1.address; s.byteenable = m1.byteenable;
                    s.read    = m1.read;    s.write      = m1.write;
                    s.wrdata  = m1.wrdata;
                    m1.rddata = s.rddata;   m1.stall     = s.stall;
                end else begin
                    s.address = m0.address; s.byteenable = m0.byteenable;
                    s.read    = m0.read;    s.write      = m0.write;
                    s.wrdata  = m0.wrdata;
                    m0.rddata = s.rddata;   m0.stall     = s.stall;
                end
            end
            if (err) begin
                bus_err = 1'b1;
                if (sel) begin
                    m1.stall = 1'b0; m1.rddata = ERR_RDDATA;
                end else begin
                    m0.stall = 1'b0; m0.rddata = ERR_RDDATA;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scoreboard bench for bus_arbiter with TIMEOUT=4: per-cycle expected
// outputs are queued at stimulus time and compared mid-cycle.
module tb_bus_arbiter;
    import bus_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic bus_err;
    int   n_tests = 0;
    int   n_fail  = 0;

    bus_arbiter_if m0_bus ();
    bus_arbiter_if m1_bus ();
    bus_arbiter_if s_bus  ();

    bus_arbiter #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .m0      (m0_bus),
        .m1      (m1_bus),
        .s       (s_bus),
        .bus_err (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        s_read, s_write;
        logic [31:0] s_address, s_wrdata;
        logic [3:0]  s_be;
        logic        m0_stall, m1_stall;
        logic [31:0] m0_rddata, m1_rddata;
        logic        bus_err;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_m0(input logic r, input logic w, input logic [31:0] a);
        m0_bus.read = r; m0_bus.write = w; m0_bus.address = a;
    endtask

    task automatic set_m1(input logic r, input logic w, input logic [31:0] a);
        m1_bus.read = r; m1_bus.write = w; m1_bus.address = a;
    endtask

    task automatic set_s(input logic st, input logic [31:0] rd);
        s_bus.stall = st; s_bus.rddata = rd;
    endtask

    // on_bus: 0 none, 1 m0, 2 m1; gnt flags select shared read data for that master.
    task automatic step_check(input string tag, input int on_bus,
                              input logic m0_st, input logic m0_gnt,
                              input logic m1_st, input logic m1_gnt,
                              input logic err);
        exp_t e, o;
        e.tag       = tag;
        e.s_read    = 1'b0; e.s_write = 1'b0;
        e.s_address = '0;   e.s_wrdata = '0; e.s_be = '0;
        if (on_bus == 1) begin
            e.s_read = m0_bus.read; e.s_write = m0_bus.write;
            e.s_address = m0_bus.address; e.s_wrdata = m0_bus.wrdata; e.s_be = m0_bus.byteenable;
        end else if (on_bus == 2) begin
            e.s_read = m1_bus.read; e.s_write = m1_bus.write;
            e.s_address = m1_bus.address; e.s_wrdata = m1_bus.wrdata; e.s_be = m1_bus.byteenable;
        end
        e.m0_stall  = m0_st;
        e.m1_stall  = m1_st;
        e.m0_rddata = m0_gnt ? s_bus.rddata : 32'h0;
        e.m1_rddata = m1_gnt ? s_bus.rddata : 32'h0;
        e.bus_err   = err;
        sb.push_back(e);
        @(negedge clk);
        o = sb.pop_front();
        check({o.tag, ".s_read"},    32'(s_bus.read),      32'(o.s_read));
        check({o.tag, ".s_write"},   32'(s_bus.write),     32'(o.s_write));
        check({o.tag, ".s_address"}, s_bus.address,        o.s_address);
        check({o.tag, ".s_wrdata"},  s_bus.wrdata,         o.s_wrdata);
        check({o.tag, ".s_be"},      32'(s_bus.byteenable), 32'(o.s_be));
        check({o.tag, ".m0_stall"},  32'(m0_bus.stall),    32'(o.m0_stall));
        check({o.tag, ".m1_stall"},  32'(m1_bus.stall),    32'(o.m1_stall));
        check({o.tag, ".m0_rddata"}, m0_bus.rddata,        o.m0_rddata);
        check({o.tag, ".m1_rddata"}, m1_bus.rddata,        o.m1_rddata);
        check({o.tag, ".bus_err"},   32'(bus_err),         32'(o.bus_err));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m0_bus.byteenable = 4'hF; m0_bus.wrdata = 32'hA0A0_0000;
        m1_bus.byteenable = 4'h3; m1_bus.wrdata = 32'hB1B1_0000;
        set_m0(1'b1, 1'b0, 32'h0000_1000);
        set_m1(1'b0, 1'b1, 32'h0000_2000);
        set_s(1'b0, 32'h1234_5678);
        @(posedge clk); #1;

        // Reset: everything forced off, requesters stalled
        step_check("rst0", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step_check("rst1", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;

        // Alternation with both requesting and no stall; m0 wins first tie
        step_check("alt0", 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        set_s(1'b0, 32'h2222_2222);
        step_check("alt1", 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step_check("alt2", 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Single m0 read completes in the same cycle
        set_m1(1'b0, 1'b0, 32'h0);
        set_m0(1'b1, 1'b0, 32'h1E00_0000);
        set_s(1'b0, 32'h1111_1111);
        step_check("single", 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        set_m0(1'b0, 1'b0, 32'h0);
        step_check("idle0", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // m1 granted (m0 served last), stalls 2 cycles, m0 waits then follows with no gap
        set_m0(1'b1, 1'b0, 32'h0000_0040);
        set_m1(1'b0, 1'b1, 32'h8000_0010);
        set_s(1'b1, 32'h3333_3333);
        step_check("busy_a", 2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step_check("busy_b", 2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        set_s(1'b0, 32'h4444_4444);
        step_check("busy_done", 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        set_m1(1'b0, 1'b0, 32'h0);
        step_check("handoff", 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        set_m0(1'b0, 1'b0, 32'h0);
        step_check("idle1", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Timeout: four stalled cycles then one ERR cycle
        set_m0(1'b1, 1'b0, 32'h0000_0080);
        set_s(1'b1, 32'h5555_5555);
        step_check("to1", 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step_check("to2", 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        set_m1(1'b1, 1'b0, 32'h8000_0020);
        step_check("to3", 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step_check("to4", 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        set_s(1'b1, 32'hDEAD_BEEF);
        step_check("err", 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        set_s(1'b0, 32'h6666_6666);
        step_check("post_err", 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        set_m1(1'b0, 1'b0, 32'h0);
        step_check("post_err_m0", 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        set_m0(1'b0, 1'b0, 32'h0);
        step_check("idle2", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Owner withdraws while BUSY: no bus_err, pending m0 granted next
        set_m1(1'b1, 1'b0, 32'h8000_0030);
        set_s(1'b1, 32'h7777_7777);
        step_check("wd_grant", 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        set_m1(1'b0, 1'b0, 32'h0);
        set_m0(1'b0, 1'b1, 32'h0000_00C0);
        step_check("wd_drop", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        set_s(1'b0, 32'h8888_8888);
        step_check("wd_next", 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        set_m0(1'b0, 1'b0, 32'h0);
        step_check("idle3", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-BUSY abandons the transaction; m0 wins first tie afterwards
        set_m1(1'b1, 1'b0, 32'h8000_0040);
        set_s(1'b1, 32'h9999_9999);
        step_check("rb_busy", 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        set_m0(1'b1, 1'b0, 32'h0000_0100);
        step_check("rb_rst0", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step_check("rb_rst1", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        set_s(1'b0, 32'hAAAA_AAAA);
        step_check("rb_tie0", 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step_check("rb_tie1", 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
